// File: rtl/lzoc_pkg.sv
// Shared types and helpers for the pipelined leading/trailing zero/one counter.
package lzoc_pkg;

    // Per-operand counting mode; it is consumed by the stage-0 normaliser.
    typedef struct packed {
        logic ones;   // 1 = count ones, 0 = count zeros
        logic trail;  // 1 = count from LSB, 0 = count from MSB
    } lzoc_mode_t;

    // Width of a run-length count able to hold 0..w inclusive.
    function automatic int lzoc_cnt_w(input int w);
        return $clog2(w) + 32'sd1;
    endfunction

endpackage

// File: rtl/lzoc_stage.sv
// One binary-search step of the leading-zero counter with its pipeline register.
// Optional feature: LZOC_NORM_EN carries and incrementally shifts the normalised operand.
module lzoc_stage
    import lzoc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int TAG_WIDTH  = 4,
    parameter int WIN        = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                flush_i,
    input  logic                                up_valid_i,
    input  logic [WIN-1:0]                      up_win_i,
    input  logic [lzoc_cnt_w(DATA_WIDTH)-1:0]   up_cnt_i,
    input  logic [TAG_WIDTH-1:0]                up_tag_i,
`ifdef LZOC_NORM_EN
    input  logic [DATA_WIDTH-1:0]               up_norm_i,
    output logic [DATA_WIDTH-1:0]               norm_o,
`endif
    input  logic                                dn_ready_i,
    output logic                                valid_o,
    output logic [WIN/2-1:0]                    win_o,
    output logic [lzoc_cnt_w(DATA_WIDTH)-1:0]   cnt_o,
    output logic [TAG_WIDTH-1:0]                tag_o
);

    localparam int CW   = lzoc_cnt_w(DATA_WIDTH);
    localparam int HALF = WIN / 2;
    localparam int BIT  = $clog2(WIN) - 1;   // count bit resolved by this step

    logic                 upper_zero_s;
    logic                 load_s;
    logic                 valid_q, valid_d;
    logic [HALF-1:0]      win_q, win_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [TAG_WIDTH-1:0] tag_q;
`ifdef LZOC_NORM_EN
    logic [DATA_WIDTH-1:0] norm_q, norm_d;
`endif

    assign upper_zero_s = ~|up_win_i[WIN-1:HALF];
    // Load when empty or when the current contents leave this cycle.
    assign load_s       = ~valid_q | dn_ready_i;

    // Search step: keep the half that still holds the first set bit.
    always_comb begin
        win_d = up_win_i[HALF-1:0];
        if (upper_zero_s) begin
            win_d = up_win_i[HALF-1:0];
        end else begin
            win_d = up_win_i[WIN-1:HALF];
        end
        cnt_d      = up_cnt_i;
        cnt_d[BIT] = upper_zero_s;
`ifdef LZOC_NORM_EN
        if (upper_zero_s) begin
            norm_d = up_norm_i << HALF;
        end else begin
            norm_d = up_norm_i;
        end
`endif
    end

    // Next valid: flush empties, a load takes the upstream valid, else hold.
    always_comb begin
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_s) begin
            valid_d = up_valid_i;
        end else begin
            valid_d = valid_q;
        end
    end

    // Occupancy flag; the only state in this stage that needs a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload registers; contents are meaningless while valid_q is low.
    always_ff @(posedge clk) begin
        if (load_s && up_valid_i) begin
            win_q  <= win_d;
            cnt_q  <= cnt_d;
            tag_q  <= up_tag_i;
`ifdef LZOC_NORM_EN
            norm_q <= norm_d;
`endif
        end
    end

    assign valid_o = valid_q;
    assign win_o   = win_q;
    assign cnt_o   = cnt_q;
    assign tag_o   = tag_q;
`ifdef LZOC_NORM_EN
    assign norm_o  = norm_q;
`endif

endmodule

// File: rtl/lzoc_pipe.sv
// Pipelined leading/trailing zero/one counter with valid/ready flow control.
// Stage 0 normalises (invert/reverse) so all later stages count leading zeros.
// Optional feature: define LZOC_NORM_EN to add the out_norm port and shift datapath.
module lzoc_pipe
    import lzoc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                flush,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [DATA_WIDTH-1:0]               in_data,
    input  logic                                in_ones,
    input  logic                                in_trail,
    input  logic [TAG_WIDTH-1:0]                in_tag,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [lzoc_cnt_w(DATA_WIDTH)-1:0]   out_cnt,
    output logic                                out_all,
`ifdef LZOC_NORM_EN
    output logic [DATA_WIDTH-1:0]               out_norm,
`endif
    output logic [TAG_WIDTH-1:0]                out_tag
);

    localparam int K  = $clog2(DATA_WIDTH);
    localparam int CW = lzoc_cnt_w(DATA_WIDTH);

    if ((DATA_WIDTH < 2) || ((DATA_WIDTH & (DATA_WIDTH - 1)) != 0)) begin : g_bad_width
        $error("lzoc_pipe: DATA_WIDTH must be a power of two >= 2");
    end

    lzoc_mode_t            mode_s;
    logic [DATA_WIDTH-1:0] inv_s, s0_data_d;
    logic                  s0_valid_q, s0_valid_d;
    logic [DATA_WIDTH-1:0] s0_data_q;
    logic [TAG_WIDTH-1:0]  s0_tag_q;

    // Stage valids (bit 0 = stage 0) and the ready each stage sees from downstream.
    logic [K:0]            valid_vec_s;
    logic [K+1:0]          rdy_vec_s;
    // Remaining windows of stages 1..K packed back to back (DW/2 + DW/4 + ... + 1).
    logic [DATA_WIDTH-2:0] win_all_s;
    logic [CW-1:0]         cnt_s [0:K];
    logic [TAG_WIDTH-1:0]  tag_s [0:K];
`ifdef LZOC_NORM_EN
    logic [DATA_WIDTH-1:0] norm_s [0:K];
`endif

    assign mode_s.ones  = in_ones;
    assign mode_s.trail = in_trail;

    // Normalise the operand so downstream only ever counts leading zeros.
    always_comb begin
        inv_s     = mode_s.ones ? ~in_data : in_data;
        s0_data_d = inv_s;
        if (mode_s.trail) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                s0_data_d[i] = inv_s[DATA_WIDTH-1-i];
            end
        end else begin
            s0_data_d = inv_s;
        end
    end

    // Ready chain without a recursive net: stage i may load unless it and
    // every stage after it are full and the output is stalled.
    always_comb begin
        logic full_s;
        full_s          = ~out_ready;
        rdy_vec_s       = '0;
        rdy_vec_s[K+1]  = out_ready;
        for (int i = K; i >= 0; i--) begin
            full_s       = full_s & valid_vec_s[i];
            rdy_vec_s[i] = ~full_s;
        end
    end

    assign in_ready = ~flush & rdy_vec_s[0];

    // Stage-0 next valid: flush empties, a free slot takes the offered operand.
    always_comb begin
        if (flush) begin
            s0_valid_d = 1'b0;
        end else if (rdy_vec_s[0]) begin
            s0_valid_d = in_valid;
        end else begin
            s0_valid_d = s0_valid_q;
        end
    end

    // Stage-0 occupancy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid_q <= 1'b0;
        end else begin
            s0_valid_q <= s0_valid_d;
        end
    end

    // Stage-0 payload, captured on an accepted handshake.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s0_data_q <= s0_data_d;
            s0_tag_q  <= in_tag;
        end
    end

    assign valid_vec_s[0] = s0_valid_q;
    assign cnt_s[0]       = '0;
    assign tag_s[0]       = s0_tag_q;
`ifdef LZOC_NORM_EN
    assign norm_s[0]      = s0_data_q;
`endif

    for (genvar k = 1; k <= K; k++) begin : g_st
        localparam int WIN     = DATA_WIDTH >> (k - 1);
        localparam int OFF     = DATA_WIDTH - (DATA_WIDTH >> (k - 1));
        localparam int OFF_PRV = DATA_WIDTH - (DATA_WIDTH >> (k - 2 < 0 ? 0 : k - 2));
        logic [WIN-1:0] up_win_s;

        if (k == 1) begin : g_first
            assign up_win_s = s0_data_q;
        end else begin : g_next
            assign up_win_s = win_all_s[OFF_PRV + WIN - 1 : OFF_PRV];
        end

        lzoc_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .TAG_WIDTH  (TAG_WIDTH),
            .WIN        (WIN)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .flush_i    (flush),
            .up_valid_i (valid_vec_s[k-1]),
            .up_win_i   (up_win_s),
            .up_cnt_i   (cnt_s[k-1]),
            .up_tag_i   (tag_s[k-1]),
`ifdef LZOC_NORM_EN
            .up_norm_i  (norm_s[k-1]),
            .norm_o     (norm_s[k]),
`endif
            .dn_ready_i (rdy_vec_s[k+1]),
            .valid_o    (valid_vec_s[k]),
            .win_o      (win_all_s[OFF + WIN/2 - 1 : OFF]),
            .cnt_o      (cnt_s[k]),
            .tag_o      (tag_s[k])
        );
    end

    assign out_valid = valid_vec_s[K];

    // Output view: the last remaining bit decides the all-matched case;
    // everything is forced to zero while no result is held.
    always_comb begin
        out_cnt  = '0;
        out_all  = 1'b0;
        out_tag  = '0;
`ifdef LZOC_NORM_EN
        out_norm = '0;
`endif
        if (valid_vec_s[K]) begin
            out_all = ~win_all_s[DATA_WIDTH-2];
            out_tag = tag_s[K];
            if (~win_all_s[DATA_WIDTH-2]) begin
                out_cnt = CW'(DATA_WIDTH);
            end else begin
                out_cnt  = cnt_s[K];
`ifdef LZOC_NORM_EN
                out_norm = norm_s[K];
`endif
            end
        end else begin
            out_cnt = '0;
        end
    end

endmodule

// File: tb/tb_lzoc_pipe.sv
// Scoreboard bench for lzoc_pipe (DATA_WIDTH=16, TAG_WIDTH=4, latency 5).
module tb_lzoc_pipe;

    localparam int DW = 16;
    localparam int TW = 4;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_ones = 1'b0;
    logic          in_trail = 1'b0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [CW-1:0] out_cnt;
    logic          out_all;
    logic [TW-1:0] out_tag;
`ifdef LZOC_NORM_EN
    logic [DW-1:0] out_norm;
`endif

    lzoc_pipe #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ones   (in_ones),
        .in_trail  (in_trail),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cnt   (out_cnt),
        .out_all   (out_all),
`ifdef LZOC_NORM_EN
        .out_norm  (out_norm),
`endif
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cnt;
        bit            all;
        int            tag;
        logic [DW-1:0] norm;
        int            acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   acc_cnt = 0;
    bit   lat_en = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: walk the operand from the chosen end and count matching bits.
    function automatic exp_t model(input logic [DW-1:0] d, input bit ones, input bit trail,
                                   input int tag, input int c);
        exp_t          e;
        int            run = 0;
        bit            stop = 1'b0;
        logic [DW-1:0] n;
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) begin
            int b = trail ? i : DW - 1 - i;
            if (!stop && d[b] == ones) run++;
            else stop = 1'b1;
        end
        n = ones ? ~d : d;
        for (int i = 0; i < DW; i++) r[i] = n[DW-1-i];
        if (trail) n = r;
        e.cnt = run;
        e.all = (run == DW);
        e.tag = tag;
        e.norm = (run == DW) ? '0 : (n << run);
        e.acc_cyc = c;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record accepted operands, compare delivered results, watch stalls.
    logic          held_v = 1'b0;
    logic [CW-1:0] held_cnt;
    logic [TW-1:0] held_tag;
    logic          held_all;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (held_v) begin
                check("stall_valid", out_valid, 1);
                check("stall_cnt", out_cnt, held_cnt);
                check("stall_tag", out_tag, held_tag);
                check("stall_all", out_all, held_all);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("cnt", out_cnt, e.cnt);
                    check("all", out_all, e.all);
                    check("tag", out_tag, e.tag);
`ifdef LZOC_NORM_EN
                    check("norm", out_norm, e.norm);
`endif
                    if (lat_en) check("latency", cyc - e.acc_cyc, 5);
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(in_data, in_ones, in_trail, int'(in_tag), cyc));
                acc_cnt++;
            end
            held_v   = out_valid & ~out_ready & ~flush;
            held_cnt = out_cnt;
            held_tag = out_tag;
            held_all = out_all;
            if (flush) sb.delete();
        end else begin
            sb.delete();
            held_v = 1'b0;
        end
    end

    // Offer one operand and hold it until accepted (bounded).
    task automatic drive(input logic [DW-1:0] d, input bit o, input bit t, input logic [TW-1:0] tg);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_ones  = o;
        in_trail = t;
        in_tag   = tg;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        if (!done) check("drive_timeout", 0, 1);
    endtask

    task automatic rand_op();
        logic [31:0]   r;
        logic [DW-1:0] d;
        bit            o;
        bit            t;
        r = $urandom;
        d = r[DW-1:0] >> $urandom_range(0, 15);
        o = 1'($urandom_range(0, 1));
        t = 1'($urandom_range(0, 1));
        if (t) d = {<<{d}};
        if (o) d = ~d;
        drive(d, o, t, TW'($urandom_range(0, 15)));
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        int a0;
        // Reset state
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_cnt", out_cnt, 0);
        check("rst_out_all", out_all, 0);
        check("rst_out_tag", out_tag, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed operands, including the boundary cases
        drive(16'h0F00, 1'b0, 1'b0, 4'd3);
        drive(16'h0000, 1'b0, 1'b0, 4'd1);
        drive(16'hFFFF, 1'b1, 1'b0, 4'd2);
        drive(16'h0008, 1'b0, 1'b1, 4'd4);
        drive(16'hFFF0, 1'b1, 1'b1, 4'd5);
        drive(16'h8000, 1'b0, 1'b0, 4'd6);
        drive(16'h0001, 1'b0, 1'b0, 4'd7);
        drive(16'h8000, 1'b0, 1'b1, 4'd8);
        drain();

        // Back-to-back random operands, mixed modes
        for (int i = 0; i < 20; i++) rand_op();
        drain();

        // Backpressure: ten cycles of offers against a stalled output
        lat_en    = 1'b0;
        out_ready = 1'b0;
        a0        = acc_cnt;
        for (int i = 0; i < 10; i++) begin
            logic [31:0] r;
            r        = $urandom;
            in_valid = 1'b1;
            in_data  = r[DW-1:0];
            in_ones  = r[16];
            in_trail = r[17];
            in_tag   = r[21:18];
            @(posedge clk);
            #1;
        end
        check("stall_accepts", acc_cnt - a0, 5);
        check("stall_in_ready", in_ready, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        lat_en = 1'b1;

        // Flush with three operations in flight and a fresh offer
        drive(16'h00F0, 1'b0, 1'b0, 4'd9);
        drive(16'h0F0F, 1'b1, 1'b1, 4'd10);
        drive(16'h1234, 1'b0, 1'b1, 4'd11);
        in_data = 16'h0001;
        in_tag  = 4'd12;
        flush   = 1'b1;
        @(negedge clk);
        check("flush_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", out_valid, 0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("flush_quiet", out_valid, 0);
        end

        // Asynchronous reset in the middle of a stream
        for (int i = 0; i < 6; i++) rand_op();
        #1 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_cnt", out_cnt, 0);
        check("arst_out_tag", out_tag, 0);
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) rand_op();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
